// File: rtl/mux_pkg.sv
// Shared definitions for the registered N:1 mux: skid-buffer state encoding
// and the out-of-range select test used by the selector.
package mux_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  localparam int unsigned MIN_NUM_IN = 2;
  localparam int unsigned MAX_NUM_IN = 16;

  // Select values at or beyond the number of wired inputs take the OOR path.
  function automatic logic sel_oor(input int unsigned sel, input int unsigned num_in);
    return sel >= num_in;
  endfunction

endpackage

// File: rtl/mux_n_comb.sv
// Pure combinational N:1 selector; unwired select codes produce OOR_VALUE
// and raise oor so the caller can flag the error.
module mux_n_comb
  import mux_pkg::*;
#(
  parameter int              WIDTH     = 32,
  parameter int              NUM_IN    = 4,
  parameter logic [WIDTH-1:0] OOR_VALUE = '0,
  localparam int             SEL_W     = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    oor
);

  if (NUM_IN < MIN_NUM_IN || NUM_IN > MAX_NUM_IN) begin : g_bad_num_in
    $error("mux_n_comb: NUM_IN must be within 2..16");
  end

  always_comb begin
    out_data = OOR_VALUE;
    oor      = sel_oor(32'(sel), NUM_IN);
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) out_data = in_data[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/mux_n_reg.sv
// Registered N:1 mux with a 2-entry skid buffer; in_ready is a flop so
// out_ready never reaches it combinationally. sel_err is sticky until reset.
module mux_n_reg
  import mux_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               NUM_IN    = 4,
  parameter logic [WIDTH-1:0] OOR_VALUE = '0,
  localparam int              SEL_W     = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  skid_state_e      state_q;
  logic [WIDTH-1:0] out_data_q;
  logic [WIDTH-1:0] skid_q;
  logic             out_valid_q;
  logic             in_ready_q;
  logic             sel_err_q;
  logic             sel_err_d;

  logic [WIDTH-1:0] mux_data;
  logic             mux_oor;
  logic             in_xfer;
  logic             out_xfer;

  mux_n_comb #(
    .WIDTH    (WIDTH),
    .NUM_IN   (NUM_IN),
    .OOR_VALUE(OOR_VALUE)
  ) u_sel (
    .in_data (in_data),
    .sel     (sel),
    .out_data(mux_data),
    .oor     (mux_oor)
  );

  assign in_xfer   = in_valid && in_ready_q;
  assign out_xfer  = out_valid_q && out_ready;
  assign sel_err_d = sel_err_q | (in_xfer & mux_oor);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_data_q  <= '0;
      sel_err_q   <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
      unique case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            out_data_q  <= mux_data;
            out_valid_q <= 1'b1;
            state_q     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            out_data_q <= mux_data;
          end else if (in_xfer) begin
            // Downstream stalled: park the new item; in_ready drops next cycle.
            skid_q     <= mux_data;
            in_ready_q <= 1'b0;
            state_q    <= ST_FULL;
          end else if (out_xfer) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            out_data_q <= skid_q;
            in_ready_q <= 1'b1;
            state_q    <= ST_ONE;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_n_reg.sv
// Directed and randomized checks of mux_n_reg across three configurations:
// NUM_IN=4/WIDTH=32, NUM_IN=5/WIDTH=32 with a custom OOR value, NUM_IN=3/WIDTH=8.
module tb_mux_n_reg;

  logic clk = 1'b0;
  logic reset;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  // NUM_IN=4, WIDTH=32, default OOR value
  logic [127:0] u4_in_data;
  logic [1:0]   u4_sel;
  logic         u4_in_valid, u4_in_ready, u4_out_valid, u4_out_ready, u4_sel_err;
  logic [31:0]  u4_out_data;

  // NUM_IN=5, WIDTH=32, OOR value 32'hBAD0_0BAD
  logic [159:0] u5_in_data;
  logic [2:0]   u5_sel;
  logic         u5_in_valid, u5_in_ready, u5_out_valid, u5_out_ready, u5_sel_err;
  logic [31:0]  u5_out_data;

  // NUM_IN=3, WIDTH=8, OOR value 8'hEE
  logic [23:0]  u3_in_data;
  logic [1:0]   u3_sel;
  logic         u3_in_valid, u3_in_ready, u3_out_valid, u3_out_ready, u3_sel_err;
  logic [7:0]   u3_out_data;

  mux_n_reg #(.WIDTH(32), .NUM_IN(4)) u4 (
    .clk(clk), .reset(reset), .in_data(u4_in_data), .sel(u4_sel),
    .in_valid(u4_in_valid), .in_ready(u4_in_ready), .out_data(u4_out_data),
    .out_valid(u4_out_valid), .out_ready(u4_out_ready), .sel_err(u4_sel_err)
  );

  mux_n_reg #(.WIDTH(32), .NUM_IN(5), .OOR_VALUE(32'hBAD0_0BAD)) u5 (
    .clk(clk), .reset(reset), .in_data(u5_in_data), .sel(u5_sel),
    .in_valid(u5_in_valid), .in_ready(u5_in_ready), .out_data(u5_out_data),
    .out_valid(u5_out_valid), .out_ready(u5_out_ready), .sel_err(u5_sel_err)
  );

  mux_n_reg #(.WIDTH(8), .NUM_IN(3), .OOR_VALUE(8'hEE)) u3 (
    .clk(clk), .reset(reset), .in_data(u3_in_data), .sel(u3_sel),
    .in_valid(u3_in_valid), .in_ready(u3_in_ready), .out_data(u3_out_data),
    .out_valid(u3_out_valid), .out_ready(u3_out_ready), .sel_err(u3_sel_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    total_cnt++; if (u4_out_valid !== 1'b0) $display("FAIL rst_u4_out_valid: got %b want 0", u4_out_valid); else pass_cnt++;
    total_cnt++; if (u4_in_ready !== 1'b1) $display("FAIL rst_u4_in_ready: got %b want 1", u4_in_ready); else pass_cnt++;
    total_cnt++; if (u4_out_data !== 32'h0) $display("FAIL rst_u4_out_data: got %h want 0", u4_out_data); else pass_cnt++;
    total_cnt++; if (u4_sel_err !== 1'b0) $display("FAIL rst_u4_sel_err: got %b want 0", u4_sel_err); else pass_cnt++;
    total_cnt++; if (u5_out_valid !== 1'b0 || u5_in_ready !== 1'b1) $display("FAIL rst_u5_hs: got v=%b r=%b want v=0 r=1", u5_out_valid, u5_in_ready); else pass_cnt++;
    total_cnt++; if (u3_out_valid !== 1'b0 || u3_in_ready !== 1'b1) $display("FAIL rst_u3_hs: got v=%b r=%b want v=0 r=1", u3_out_valid, u3_in_ready); else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_basic;
    u4_in_data = {32'h4444_4444, 32'hDEAD_BEEF, 32'h2222_2222, 32'h1111_1111};
    u4_sel = 2'd2; u4_in_valid = 1'b1; u4_out_ready = 1'b1;
    tick();
    u4_in_valid = 1'b0;
    total_cnt++; if (u4_out_valid !== 1'b1) $display("FAIL basic_out_valid: got %b want 1", u4_out_valid); else pass_cnt++;
    total_cnt++; if (u4_out_data !== 32'hDEAD_BEEF) $display("FAIL basic_out_data: got %h want deadbeef", u4_out_data); else pass_cnt++;
    total_cnt++; if (u4_sel_err !== 1'b0) $display("FAIL basic_sel_err: got %b want 0", u4_sel_err); else pass_cnt++;
    tick();
    total_cnt++; if (u4_out_valid !== 1'b0) $display("FAIL basic_drain: got %b want 0", u4_out_valid); else pass_cnt++;
    u4_sel = 2'd3; u4_in_valid = 1'b1;
    tick();
    u4_in_valid = 1'b0;
    total_cnt++; if (u4_out_data !== 32'h4444_4444) $display("FAIL basic_sel3_data: got %h want 44444444", u4_out_data); else pass_cnt++;
    total_cnt++; if (u4_sel_err !== 1'b0) $display("FAIL basic_pow2_sel_err: got %b want 0", u4_sel_err); else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back;
    logic [31:0] val;
    u4_out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      val = 32'h1000_0000 + 32'(i);
      u4_sel = 2'(i % 4);
      u4_in_data = {4{~val}};
      u4_in_data[(i % 4)*32 +: 32] = val;
      u4_in_valid = 1'b1;
      tick();
      total_cnt++; if (u4_in_ready !== 1'b1) $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, u4_in_ready); else pass_cnt++;
      total_cnt++; if (u4_out_valid !== 1'b1 || u4_out_data !== val) $display("FAIL b2b_data[%0d]: got v=%b d=%h want v=1 d=%h", i, u4_out_valid, u4_out_data, val); else pass_cnt++;
    end
    u4_in_valid = 1'b0;
    tick();
    total_cnt++; if (u4_out_valid !== 1'b0) $display("FAIL b2b_drain: got %b want 0", u4_out_valid); else pass_cnt++;
  endtask

  task automatic test_backpressure;
    u5_in_data = {32'hBBBB_0004, 32'h3, 32'h2, 32'hAAAA_0001, 32'h0};
    u5_out_ready = 1'b0; u5_sel = 3'd1; u5_in_valid = 1'b1;
    tick();
    total_cnt++; if (u5_out_valid !== 1'b1 || u5_out_data !== 32'hAAAA_0001) $display("FAIL bp_first: got v=%b d=%h want v=1 d=aaaa0001", u5_out_valid, u5_out_data); else pass_cnt++;
    total_cnt++; if (u5_in_ready !== 1'b1) $display("FAIL bp_one_ready: got %b want 1", u5_in_ready); else pass_cnt++;
    u5_sel = 3'd4;
    tick();
    total_cnt++; if (u5_in_ready !== 1'b0) $display("FAIL bp_full_ready: got %b want 0", u5_in_ready); else pass_cnt++;
    total_cnt++; if (u5_out_data !== 32'hAAAA_0001) $display("FAIL bp_full_hold: got %h want aaaa0001", u5_out_data); else pass_cnt++;
    u5_sel = 3'd7;
    tick();
    total_cnt++; if (u5_out_data !== 32'hAAAA_0001 || u5_in_ready !== 1'b0) $display("FAIL bp_stall: got d=%h r=%b want d=aaaa0001 r=0", u5_out_data, u5_in_ready); else pass_cnt++;
    total_cnt++; if (u5_sel_err !== 1'b0) $display("FAIL bp_oor_not_ready: got %b want 0", u5_sel_err); else pass_cnt++;
    u5_in_valid = 1'b0; u5_out_ready = 1'b1;
    tick();
    total_cnt++; if (u5_out_valid !== 1'b1 || u5_out_data !== 32'hBBBB_0004) $display("FAIL bp_second: got v=%b d=%h want v=1 d=bbbb0004", u5_out_valid, u5_out_data); else pass_cnt++;
    total_cnt++; if (u5_in_ready !== 1'b1) $display("FAIL bp_ready_back: got %b want 1", u5_in_ready); else pass_cnt++;
    tick();
    total_cnt++; if (u5_out_valid !== 1'b0) $display("FAIL bp_empty: got %b want 0", u5_out_valid); else pass_cnt++;
    tick();
    total_cnt++; if (u5_sel_err !== 1'b0) $display("FAIL bp_oor_no_valid: got %b want 0", u5_sel_err); else pass_cnt++;
  endtask

  task automatic test_oor;
    u5_in_data = {32'h4, 32'h3, 32'h2, 32'h1, 32'h0000_C0DE};
    u5_out_ready = 1'b1; u5_sel = 3'd7; u5_in_valid = 1'b1;
    tick();
    total_cnt++; if (u5_out_data !== 32'hBAD0_0BAD) $display("FAIL oor_data7: got %h want bad00bad", u5_out_data); else pass_cnt++;
    total_cnt++; if (u5_sel_err !== 1'b1) $display("FAIL oor_set: got %b want 1", u5_sel_err); else pass_cnt++;
    u5_sel = 3'd0;
    tick();
    total_cnt++; if (u5_out_data !== 32'h0000_C0DE || u5_sel_err !== 1'b1) $display("FAIL oor_sticky_valid: got d=%h e=%b want d=0000c0de e=1", u5_out_data, u5_sel_err); else pass_cnt++;
    u5_sel = 3'd5;
    tick();
    total_cnt++; if (u5_out_data !== 32'hBAD0_0BAD) $display("FAIL oor_data5: got %h want bad00bad", u5_out_data); else pass_cnt++;
    u5_in_valid = 1'b0;
    tick();
    total_cnt++; if (u5_sel_err !== 1'b1 || u5_out_valid !== 1'b0) $display("FAIL oor_sticky_idle: got e=%b v=%b want e=1 v=0", u5_sel_err, u5_out_valid); else pass_cnt++;
  endtask

  task automatic test_reset_full;
    u5_in_data = {32'h4, 32'h3333_3333, 32'h1111_1111, 32'hE000_000E, 32'hDDDD_DDDD};
    u5_out_ready = 1'b0; u5_sel = 3'd2; u5_in_valid = 1'b1;
    tick();
    u5_sel = 3'd3;
    tick();
    total_cnt++; if (u5_in_ready !== 1'b0) $display("FAIL rf_full: got %b want 0", u5_in_ready); else pass_cnt++;
    reset = 1'b1; u5_sel = 3'd0; u5_out_ready = 1'b1;
    tick();
    reset = 1'b0;
    total_cnt++; if (u5_out_valid !== 1'b0 || u5_in_ready !== 1'b1) $display("FAIL rf_hs: got v=%b r=%b want v=0 r=1", u5_out_valid, u5_in_ready); else pass_cnt++;
    total_cnt++; if (u5_sel_err !== 1'b0 || u5_out_data !== 32'h0) $display("FAIL rf_clear: got e=%b d=%h want e=0 d=0", u5_sel_err, u5_out_data); else pass_cnt++;
    u5_sel = 3'd1;
    tick();
    u5_in_valid = 1'b0;
    total_cnt++; if (u5_out_valid !== 1'b1 || u5_out_data !== 32'hE000_000E) $display("FAIL rf_first_after: got v=%b d=%h want v=1 d=e000000e", u5_out_valid, u5_out_data); else pass_cnt++;
    tick();
    total_cnt++; if (u5_out_valid !== 1'b0) $display("FAIL rf_no_stale: got v=%b d=%h want v=0", u5_out_valid, u5_out_data); else pass_cnt++;
  endtask

  task automatic test_random;
    logic [7:0] sb_q[$];
    logic [7:0] exp_v;
    logic       saw_oor;
    saw_oor = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      u3_in_valid  = ($urandom_range(0, 99) < 60);
      u3_out_ready = ($urandom_range(0, 99) < 55);
      u3_in_data   = 24'($urandom);
      u3_sel       = 2'($urandom_range(0, 3));
      if (u3_in_valid && u3_in_ready) begin
        exp_v = (u3_sel < 2'd3) ? u3_in_data[int'(u3_sel)*8 +: 8] : 8'hEE;
        if (u3_sel == 2'd3) saw_oor = 1'b1;
        sb_q.push_back(exp_v);
      end
      if (u3_out_valid && u3_out_ready) begin
        total_cnt++;
        if (sb_q.size() == 0) $display("FAIL rnd_extra[%0d]: got %h want no item", c, u3_out_data);
        else begin
          exp_v = sb_q.pop_front();
          if (u3_out_data !== exp_v) $display("FAIL rnd_data[%0d]: got %h want %h", c, u3_out_data, exp_v); else pass_cnt++;
        end
      end
      tick();
    end
    u3_in_valid = 1'b0; u3_out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (u3_out_valid) begin
        total_cnt++;
        if (sb_q.size() == 0) $display("FAIL rnd_drain_extra: got %h want no item", u3_out_data);
        else begin
          exp_v = sb_q.pop_front();
          if (u3_out_data !== exp_v) $display("FAIL rnd_drain: got %h want %h", u3_out_data, exp_v); else pass_cnt++;
        end
      end
      tick();
    end
    total_cnt++; if (sb_q.size() != 0 || u3_out_valid !== 1'b0) $display("FAIL rnd_lost: got %0d pending, v=%b want 0 pending", sb_q.size(), u3_out_valid); else pass_cnt++;
    total_cnt++; if (u3_sel_err !== saw_oor) $display("FAIL rnd_sel_err: got %b want %b", u3_sel_err, saw_oor); else pass_cnt++;
    total_cnt++; if (u4_sel_err !== 1'b0) $display("FAIL pow2_sel_err_final: got %b want 0", u4_sel_err); else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1;
    u4_in_data = '0; u4_sel = '0; u4_in_valid = 1'b0; u4_out_ready = 1'b0;
    u5_in_data = '0; u5_sel = '0; u5_in_valid = 1'b0; u5_out_ready = 1'b0;
    u3_in_data = '0; u3_sel = '0; u3_in_valid = 1'b0; u3_out_ready = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_oor();
    test_reset_full();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
